// File: rtl/tdc_pkg.sv
// tdc_pkg: shared state encoding, depth word width and default slot timing for the shot controller
package tdc_pkg;
  typedef enum logic [1:0] {IDLE, ARM, WAIT_RES, DONE} state_t;
  localparam int DW            = 15;
  localparam int PERIOD_DEF    = 641;
  localparam int START_OFS_DEF = 10;
endpackage

// File: rtl/tdc_slot_timer.sv
// tdc_slot_timer: shot-slot period counter (0..PERIOD-1) with a strobe at START_OFS
// Ports: clk, rst (sync, active-high), clr (hold counter at 0), strobe (counter == START_OFS)
module tdc_slot_timer #(
  parameter int PERIOD    = tdc_pkg::PERIOD_DEF,
  parameter int START_OFS = tdc_pkg::START_OFS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic strobe
);
  localparam int CW = $clog2(PERIOD);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else cnt <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + CW'(1);
  assign strobe = cnt == CW'(START_OFS);
endmodule

// File: rtl/tdc_shot_ctrl.sv
// tdc_shot_ctrl: launches one TDC start per shot slot, counts a frame of shots, then collects one histogram depth word
// Ports: clk, rst (sync, active-high), en (run frames), cfg_shots (shots/frame, 0 means 1), busy (TDC cannot start),
//        TDC_start (start pulse), HIS_Odata/HIS_Ovalid/HIS_Oready (histogram result stream),
//        depth_o/depth_valid (captured depth), depth_timeout, frame_done, shot_cnt_o, skip_cnt_o
// All pulses are registered: depth_valid/depth_timeout appear in the DONE cycle, frame_done one cycle later.
module tdc_shot_ctrl #(
  parameter int PERIOD    = tdc_pkg::PERIOD_DEF,
  parameter int START_OFS = tdc_pkg::START_OFS_DEF,
  parameter int DW        = tdc_pkg::DW,
  parameter int TO_CYC    = 4096,
  parameter int SHOT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [SHOT_W-1:0] cfg_shots,
  input  logic              busy,
  output logic              TDC_start,
  input  logic [DW-1:0]     HIS_Odata,
  input  logic              HIS_Ovalid,
  output logic              HIS_Oready,
  output logic [DW-1:0]     depth_o,
  output logic              depth_valid,
  output logic              depth_timeout,
  output logic              frame_done,
  output logic [SHOT_W-1:0] shot_cnt_o,
  output logic [SHOT_W-1:0] skip_cnt_o
);
  import tdc_pkg::*;
  localparam int TW = $clog2(TO_CYC);
  state_t state, nxt;
  logic strobe, hs, fire, skip, cap, tmo, start_frame, clr_cnt;
  logic [TW-1:0] timer;
  logic [SHOT_W-1:0] shots_lat;
  tdc_slot_timer #(.PERIOD(PERIOD), .START_OFS(START_OFS)) u_slot (
    .clk(clk),
    .rst(rst),
    .clr(state != ARM),
    .strobe(strobe)
  );
  assign HIS_Oready  = (state == ARM) || (state == WAIT_RES);
  assign hs          = HIS_Ovalid && HIS_Oready;
  assign start_frame = (nxt == ARM) && (state != ARM);
  assign clr_cnt     = start_frame || (nxt == IDLE);
  // abort beats a result, a result beats both shot launch and timeout
  always_comb begin
    nxt  = state;
    fire = 1'b0;
    skip = 1'b0;
    cap  = 1'b0;
    tmo  = 1'b0;
    case (state)
      IDLE: nxt = en ? ARM : IDLE;
      ARM:
        if (!en) nxt = IDLE;
        else if (hs) begin
          cap = 1'b1;
          nxt = DONE;
        end else if (shot_cnt_o == shots_lat) nxt = WAIT_RES;
        else begin
          fire = strobe && !busy;
          skip = strobe && busy;
        end
      WAIT_RES:
        if (!en) nxt = IDLE;
        else if (hs) begin
          cap = 1'b1;
          nxt = DONE;
        end else if (timer == TW'(TO_CYC - 1)) begin
          tmo = 1'b1;
          nxt = DONE;
        end
      default: nxt = en ? ARM : IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state         <= IDLE;
      TDC_start     <= 1'b0;
      depth_o       <= '0;
      depth_valid   <= 1'b0;
      depth_timeout <= 1'b0;
      frame_done    <= 1'b0;
      shot_cnt_o    <= '0;
      skip_cnt_o    <= '0;
      shots_lat     <= '0;
      timer         <= '0;
    end else begin
      state         <= nxt;
      TDC_start     <= fire;
      depth_valid   <= cap;
      depth_timeout <= tmo;
      frame_done    <= state == DONE;
      timer         <= (state == WAIT_RES) ? timer + TW'(1) : '0;
      if (cap) depth_o <= HIS_Odata;
      if (start_frame) shots_lat <= (cfg_shots == '0) ? SHOT_W'(1) : cfg_shots;
      shot_cnt_o    <= clr_cnt ? '0 : shot_cnt_o + SHOT_W'(fire);
      skip_cnt_o    <= clr_cnt ? '0 : skip_cnt_o + SHOT_W'(skip && !(&skip_cnt_o));
    end
endmodule

// File: tb/tb_tdc_shot_ctrl.sv
// tb_tdc_shot_ctrl: directed self-checking bench for tdc_shot_ctrl at default parameters
module tb_tdc_shot_ctrl;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, busy = 1'b0, HIS_Ovalid = 1'b0;
  logic [15:0] cfg_shots = '0;
  logic [14:0] HIS_Odata = '0;
  logic TDC_start, HIS_Oready, depth_valid, depth_timeout, frame_done;
  logic [14:0] depth_o;
  logic [15:0] shot_cnt_o, skip_cnt_o;
  int errs = 0, checks = 0, n_start = 0, n_fd = 0, consec = 0, s0 = 0, fd0 = 0;
  logic prev = 1'b0;
  tdc_shot_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .cfg_shots(cfg_shots), .busy(busy),
    .TDC_start(TDC_start), .HIS_Odata(HIS_Odata), .HIS_Ovalid(HIS_Ovalid), .HIS_Oready(HIS_Oready),
    .depth_o(depth_o), .depth_valid(depth_valid), .depth_timeout(depth_timeout), .frame_done(frame_done),
    .shot_cnt_o(shot_cnt_o), .skip_cnt_o(skip_cnt_o)
  );
  always #2 clk = ~clk;
  always @(posedge clk) begin
    if (TDC_start) begin
      n_start++;
      if (prev) consec++;
    end
    if (frame_done) n_fd++;
    prev = TDC_start;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick(2);
    chk("rst_flags", {TDC_start, HIS_Oready, depth_valid, depth_timeout, frame_done}, 0);
    chk("rst_depth", depth_o, 0);
    chk("rst_cnts", {shot_cnt_o, skip_cnt_o}, 0);
    rst = 1'b0; cfg_shots = 16'd3; en = 1'b1;
    tick(1);
    chk("t1_ready", HIS_Oready, 1);
    chk("t1_c0_start", TDC_start, 0);
    tick(10); chk("t1_c10_start", TDC_start, 0);
    tick(1);  chk("t1_c11_start", TDC_start, 1); chk("t1_c11_shot", shot_cnt_o, 1);
    tick(1);  chk("t1_c12_start", TDC_start, 0);
    tick(640); chk("t1_c652_start", TDC_start, 1); chk("t1_c652_shot", shot_cnt_o, 2);
    tick(641); chk("t1_c1293_start", TDC_start, 1); chk("t1_c1293_shot", shot_cnt_o, 3);
    tick(1);  chk("t1_wait_start", TDC_start, 0); chk("t1_wait_ready", HIS_Oready, 1);
    tick(19);
    HIS_Odata = 15'h1234; HIS_Ovalid = 1'b1;
    tick(1);
    chk("t1_dv", depth_valid, 1); chk("t1_depth", depth_o, 15'h1234); chk("t1_fd_early", frame_done, 0);
    HIS_Ovalid = 1'b0; cfg_shots = 16'd2; busy = 1'b1;
    tick(1);
    chk("t1_fd", frame_done, 1); chk("t1_dv_off", depth_valid, 0);
    chk("t1_new_shot", shot_cnt_o, 0); chk("t1_new_ready", HIS_Oready, 1);
    tick(11);
    chk("t2_skip_start", TDC_start, 0); chk("t2_skip", skip_cnt_o, 1); chk("t2_shot0", shot_cnt_o, 0);
    busy = 1'b0;
    tick(641); chk("t2_s2_start", TDC_start, 1); chk("t2_s2_shot", shot_cnt_o, 1);
    tick(641); chk("t2_s3_start", TDC_start, 1); chk("t2_s3_shot", shot_cnt_o, 2); chk("t2_s3_skip", skip_cnt_o, 1);
    cfg_shots = 16'd1;
    tick(1);
    HIS_Odata = 15'h0777; HIS_Ovalid = 1'b1;
    tick(1);
    chk("t2_dv", depth_valid, 1); chk("t2_depth", depth_o, 15'h0777);
    HIS_Ovalid = 1'b0;
    tick(1); chk("t2_fd", frame_done, 1);
    tick(11); chk("t3_start", TDC_start, 1); chk("t3_shot", shot_cnt_o, 1);
    tick(1);
    tick(4095); chk("t3_to_early", depth_timeout, 0);
    tick(1);
    chk("t3_to", depth_timeout, 1); chk("t3_dv", depth_valid, 0);
    chk("t3_depth_held", depth_o, 15'h0777); chk("t3_fd_early", frame_done, 0);
    cfg_shots = 16'd4;
    tick(1); chk("t3_fd", frame_done, 1); chk("t3_to_off", depth_timeout, 0);
    s0 = n_start;
    tick(11); chk("t4_start", TDC_start, 1); chk("t4_shot", shot_cnt_o, 1);
    tick(9);
    HIS_Odata = 15'h0042; HIS_Ovalid = 1'b1;
    tick(1);
    chk("t4_dv", depth_valid, 1); chk("t4_depth", depth_o, 15'h0042); chk("t4_shot_held", shot_cnt_o, 1);
    HIS_Ovalid = 1'b0; cfg_shots = 16'd2;
    tick(1);
    chk("t4_fd", frame_done, 1); chk("t4_nstart", n_start - s0, 1);
    tick(11); chk("t5_start", TDC_start, 1);
    fd0 = n_fd;
    tick(100);
    en = 1'b0;
    tick(1);
    chk("t5_abort_ready", HIS_Oready, 0); chk("t5_abort_shot", shot_cnt_o, 0);
    chk("t5_abort_start", TDC_start, 0); chk("t5_abort_depth", depth_o, 15'h0042);
    tick(5); chk("t5_abort_nofd", n_fd - fd0, 0);
    en = 1'b1; cfg_shots = 16'd1;
    tick(12); chk("t5b_start", TDC_start, 1);
    tick(51);
    chk("t5b_wait_ready", HIS_Oready, 1);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_flags", {TDC_start, HIS_Oready, depth_valid, depth_timeout, frame_done}, 0);
    chk("t5_rst_depth", depth_o, 0); chk("t5_rst_cnts", {shot_cnt_o, skip_cnt_o}, 0);
    rst = 1'b0; en = 1'b0; cfg_shots = 16'd0;
    tick(3); chk("t5_rst_nofd", n_fd - fd0, 0); chk("t5_idle_ready", HIS_Oready, 0);
    s0 = n_start; en = 1'b1;
    tick(12); chk("t6_start", TDC_start, 1); chk("t6_shot", shot_cnt_o, 1);
    tick(1);  chk("t6_wait_start", TDC_start, 0);
    tick(4095); chk("t6_one_shot", shot_cnt_o, 1);
    HIS_Odata = 15'h5A5A; HIS_Ovalid = 1'b1;
    tick(1);
    chk("t6_dv", depth_valid, 1); chk("t6_to", depth_timeout, 0); chk("t6_depth", depth_o, 15'h5A5A);
    HIS_Ovalid = 1'b0; en = 1'b0;
    tick(1); chk("t6_fd", frame_done, 1); chk("t6_nstart", n_start - s0, 1);
    tick(1); chk("t6_idle_ready", HIS_Oready, 0); chk("t6_idle_shot", shot_cnt_o, 0);
    chk("no_back_to_back_start", consec, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
